midi_tx_scheduler: RTL

- Arbitrates between two MIDI event requesters (note on/off from the pitch path, control change from the volume path).
- Formats each granted event as a 3-byte MIDI message and sequences the bytes into the 31250-baud serial byte transmitter through its send/ready handshake.
- Optional running-status compression: a status byte identical to the last one transmitted is omitted.
- Sits between the theremin pitch/volume logic and the MIDI UART.

---
 rtl/midi_tx_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/midi_tx_scheduler.sv
// midi_tx_scheduler
// Grants one of two MIDI event requesters (note path, CC path), builds the
// 3-byte message and feeds it byte by byte into the MIDI UART using its
// send/ready handshake. Optional running-status compression drops a status
// byte equal to the last status byte actually transmitted.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no message in flight; arbitrate pending requests
// LOAD      | message captured; choose first byte (status or data 1)
// SEND      | wait for transmitter ready, then strobe the current byte
// WAIT_LOW  | wait for transmitter to drop ready (byte accepted)
// WAIT_HIGH | wait for ready to return (stop bit done); next byte or end
`timescale 1ns/1ps

module midi_tx_scheduler #(
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] channel,
  input  logic       note_req,
  input  logic       note_on,
  input  logic [6:0] note_num,
  input  logic [6:0] note_vel,
  output logic       note_ack,
  input  logic       cc_req,
  input  logic [6:0] cc_num,
  input  logic [6:0] cc_val,
  output logic       cc_ack,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_LOW  = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] msg_status;
  logic [7:0] msg_d1;
  logic [7:0] msg_d2;
  logic [1:0] byte_idx;
  logic [7:0] last_status;
  // 1 = the CC requester was granted most recently, so the note path wins a tie
  logic       rr_last_cc;

  logic       grant_note;
  logic       grant_cc;
  logic [7:0] cur_byte;

  // Round-robin arbitration between the two requesters
  always_comb begin
    grant_note = note_req && (!cc_req || rr_last_cc);
    grant_cc   = cc_req && !grant_note;
  end

  // Select the message byte addressed by byte_idx
  always_comb begin
    cur_byte = msg_d2;
    if (byte_idx == 2'd0) begin
      cur_byte = msg_status;
    end else if (byte_idx == 2'd1) begin
      cur_byte = msg_d1;
    end
  end

  // Scheduler FSM with registered outputs and message buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      msg_status  <= 8'h00;
      msg_d1      <= 8'h00;
      msg_d2      <= 8'h00;
      byte_idx    <= 2'd0;
      last_status <= 8'h00;
      rr_last_cc  <= 1'b1;
      note_ack    <= 1'b0;
      cc_ack      <= 1'b0;
      tx_data     <= 8'h00;
      tx_send     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      note_ack <= 1'b0;
      cc_ack   <= 1'b0;
      tx_send  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_note) begin
            note_ack   <= 1'b1;
            msg_status <= {1'b1, (note_on ? 3'b001 : 3'b000), channel};
            msg_d1     <= {1'b0, note_num};
            msg_d2     <= {1'b0, note_vel};
            rr_last_cc <= 1'b0;
            busy       <= 1'b1;
            state      <= LOAD;
          end else if (grant_cc) begin
            cc_ack     <= 1'b1;
            msg_status <= {4'hB, channel};
            msg_d1     <= {1'b0, cc_num};
            msg_d2     <= {1'b0, cc_val};
            rr_last_cc <= 1'b1;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          // last_status resets to 0x00, which is never a valid status byte
          if (RUNNING_STATUS && (msg_status == last_status)) begin
            byte_idx <= 2'd1;
          end else begin
            byte_idx <= 2'd0;
          end
          state <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_data <= cur_byte;
            tx_send <= 1'b1;
            if (byte_idx == 2'd0) begin
              last_status <= msg_status;
            end
            state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!tx_ready) begin
            state <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (tx_ready) begin
            if (byte_idx == 2'd2) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= SEND;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
